regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two sources:
  - the in-order pipeline writeback (WB);
  - a long-latency (LL) return path for multiply/divide results and load-miss refills.
- Buffers LL results in a small FIFO and drives the register file write port from registers.
- Keeps a busy scoreboard of LL destinations so decode can stall RAW/WAW hazards.
- Sits between the WB stage, the LL units and the register file.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback has priority over a small FIFO of
// long-latency results, with a busy scoreboard of outstanding LL destinations for decode.
module regfile_wb_arbiter #(
  parameter int W            = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         wb_valid,
  input  logic [4:0]   wb_addr,
  input  logic [W-1:0] wb_data,
  input  logic         ll_valid,
  output logic         ll_ready,
  input  logic [4:0]   ll_addr,
  input  logic [W-1:0] ll_data,
  input  logic         iss_valid,
  input  logic [4:0]   iss_addr,
  input  logic [4:0]   rs_addr,
  input  logic [4:0]   rt_addr,
  output logic         rs_busy,
  output logic         rt_busy,
  output logic         pipe_stall,
  output logic         write_en,
  output logic [4:0]   write_reg_addr,
  output logic [W-1:0] write_reg_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT);

  // Handshake: an LL entry transfers on any edge where ll_valid && ll_ready; WB has no
  // ready and is always consumed in the cycle it is presented.

  logic [4:0]    fifo_addr [DEPTH];
  logic [W-1:0]  fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic [CW-1:0] starve_cnt;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       blocked;
  logic [4:0] head_addr;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign ll_ready  = !full;
  assign push      = ll_valid && ll_ready;
  // Pop decision uses the registered count, so a push into an empty FIFO is never bypassed.
  assign pop       = !wb_valid && !empty;
  assign blocked   = wb_valid && !empty;
  assign head_addr = fifo_addr[rd_ptr];

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ll_addr;
      fifo_data[wr_ptr] <= ll_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear on pop first, then set on issue, so a same-edge set of that register wins.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_addr] = 1'b0;
    if (iss_valid && (iss_addr != 5'd0)) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else if (blocked) begin
      if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        pipe_stall <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + CW'(1);
        pipe_stall <= 1'b0;
      end
    end else begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end
  end

  // Writes to r0 are consumed silently; address and data only move on a real write.
  always_ff @(posedge CLK) begin
    if (reset) begin
      write_en       <= 1'b0;
      write_reg_addr <= '0;
      write_reg_data <= '0;
    end else begin
      write_en <= 1'b0;
      if (wb_valid) begin
        if (wb_addr != 5'd0) begin
          write_en       <= 1'b1;
          write_reg_addr <= wb_addr;
          write_reg_data <= wb_data;
        end
      end else if (pop && (head_addr != 5'd0)) begin
        write_en       <= 1'b1;
        write_reg_addr <= head_addr;
        write_reg_data <= fifo_data[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run, all checked
// against a queue-based model of the arbiter's write port, scoreboard and stall pulse.
module tb_regfile_wb_arbiter;
  localparam int W            = 32;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic         CLK = 1'b0;
  logic         reset;
  logic         wb_valid;
  logic [4:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         ll_valid;
  logic         ll_ready;
  logic [4:0]   ll_addr;
  logic [W-1:0] ll_data;
  logic         iss_valid;
  logic [4:0]   iss_addr;
  logic [4:0]   rs_addr;
  logic [4:0]   rt_addr;
  logic         rs_busy;
  logic         rt_busy;
  logic         pipe_stall;
  logic         write_en;
  logic [4:0]   write_reg_addr;
  logic [W-1:0] write_reg_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W+4:0] exp_q[$];
  logic [31:0]  m_busy  = '0;
  int           m_run   = 0;
  logic         m_stall = 1'b0;
  logic         m_we    = 1'b0;
  logic [4:0]   m_addr  = '0;
  logic [W-1:0] m_data  = '0;

  regfile_wb_arbiter #(.W(W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .pipe_stall(pipe_stall), .write_en(write_en),
    .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data)
  );

  always #5 CLK = ~CLK;

  // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
  task automatic tick();
    logic [W+4:0] head;
    logic         do_push;
    logic         do_pop;
    logic         is_blocked;
    do_push    = ll_valid && (exp_q.size() < DEPTH);
    do_pop     = !wb_valid && (exp_q.size() != 0);
    is_blocked = wb_valid && (exp_q.size() != 0);
    head       = do_pop ? exp_q[0] : '0;
    @(posedge CLK);
    if (reset) begin
      exp_q.delete();
      m_busy = '0; m_run = 0; m_stall = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_we = 1'b0;
      if (wb_valid) begin
        if (wb_addr != 0) begin m_we = 1'b1; m_addr = wb_addr; m_data = wb_data; end
      end else if (do_pop && head[W+4:W] != 0) begin
        m_we = 1'b1; m_addr = head[W+4:W]; m_data = head[W-1:0];
      end
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_busy[head[W+4:W]] = 1'b0;
      end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (do_push) exp_q.push_back({ll_addr, ll_data});
      m_run   = is_blocked ? m_run + 1 : 0;
      m_stall = is_blocked && (m_run % STARVE_LIMIT == 0);
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0;
    iss_valid = 0; iss_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rs_addr = 5'd3; rt_addr = 5'd17;
    reset = 1; tick(); tick(); reset = 0;
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", write_en); end
    n_vec++; if (write_reg_addr !== 5'd0 || write_reg_data !== '0) begin
      n_err++; $display("FAIL reset_addr_data got %0d/%h exp 0/0", write_reg_addr, write_reg_data); end
    n_vec++; if (ll_ready !== 1'b1) begin n_err++; $display("FAIL reset_ll_ready got %b exp 1", ll_ready); end
    n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", pipe_stall); end
    n_vec++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b%b exp 00", rs_busy, rt_busy); end
  endtask

  task automatic test_wb_write();
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick(); idle_inputs();
    n_vec++; if (write_en !== 1'b1 || write_reg_addr !== 5'd5 || write_reg_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wb_write got %b/%0d/%h exp 1/5/deadbeef", write_en, write_reg_addr, write_reg_data); end
    tick();
    n_vec++; if (write_en !== 1'b0 || write_reg_addr !== 5'd5 || write_reg_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wb_hold got %b/%0d/%h exp 0/5/deadbeef", write_en, write_reg_addr, write_reg_data); end
  endtask

  task automatic test_scoreboard();
    rs_addr = 5'd9; iss_valid = 1; iss_addr = 5'd9;
    tick(); iss_valid = 0;
    n_vec++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_set got %b exp 1", rs_busy); end
    ll_valid = 1; ll_addr = 5'd9; ll_data = 32'h1234;
    tick(); ll_valid = 0;
    n_vec++; if (write_en !== 1'b0 || rs_busy !== 1'b1) begin
      n_err++; $display("FAIL sb_no_bypass got we=%b busy=%b exp we=0 busy=1", write_en, rs_busy); end
    tick();
    n_vec++; if (write_en !== 1'b1 || write_reg_addr !== 5'd9 || write_reg_data !== 32'h1234) begin
      n_err++; $display("FAIL sb_ll_write got %b/%0d/%h exp 1/9/1234", write_en, write_reg_addr, write_reg_data); end
    n_vec++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL sb_clear got %b exp 0", rs_busy); end
  endtask

  task automatic test_set_wins();
    rs_addr = 5'd7; iss_valid = 1; iss_addr = 5'd7;
    ll_valid = 1; ll_addr = 5'd7; ll_data = 32'h7777;
    tick(); ll_valid = 0;
    tick(); iss_valid = 0;
    n_vec++; if (write_en !== 1'b1 || write_reg_addr !== 5'd7) begin
      n_err++; $display("FAIL setwins_write got %b/%0d exp 1/7", write_en, write_reg_addr); end
    n_vec++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL setwins_busy got %b exp 1", rs_busy); end
    tick();
    n_vec++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL setwins_hold got %b exp 1", rs_busy); end
  endtask

  task automatic test_starvation();
    int waited;
    wb_valid = 1; wb_addr = 5'd20; wb_data = 32'h2020;
    for (int i = 1; i <= 4; i++) begin
      ll_valid = 1; ll_addr = 5'(i); ll_data = 32'hA000_0000 + i;
      tick();
    end
    ll_valid = 0;
    n_vec++; if (ll_ready !== 1'b0) begin n_err++; $display("FAIL starve_full got %b exp 0", ll_ready); end
    n_vec++; if (write_en !== 1'b1 || write_reg_addr !== 5'd20) begin
      n_err++; $display("FAIL starve_wb_wins got %b/%0d exp 1/20", write_en, write_reg_addr); end
    n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL starve_early got %b exp 0", pipe_stall); end
    waited = 0;
    while (pipe_stall !== 1'b1 && waited < 20) begin tick(); waited++; end
    n_vec++; if (waited != 5) begin n_err++; $display("FAIL starve_delay got %0d exp 5", waited); end
    wb_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++; if (write_en !== 1'b1 || write_reg_addr !== 5'(i) || write_reg_data !== 32'hA000_0000 + i) begin
        n_err++; $display("FAIL drain_%0d got %b/%0d/%h exp 1/%0d", i, write_en, write_reg_addr, write_reg_data, i); end
      n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL stall_pulse_%0d got %b exp 0", i, pipe_stall); end
    end
    n_vec++; if (ll_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready got %b exp 1", ll_ready); end
    tick();
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL drain_done got %b exp 0", write_en); end
  endtask

  task automatic test_r0();
    rs_addr = 5'd0;
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick(); idle_inputs();
    ll_valid = 1; ll_addr = 5'd0; ll_data = 32'h5555; iss_valid = 1; iss_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (write_en !== 1'b0 || rs_busy !== 1'b0) begin
        n_err++; $display("FAIL r0_cycle%0d got we=%b busy0=%b exp 0/0", i, write_en, rs_busy); end
      tick(); idle_inputs();
    end
    n_vec++; if (ll_ready !== 1'b1 || write_reg_addr !== 5'd4) begin
      n_err++; $display("FAIL r0_consumed got ready=%b addr=%0d exp 1/4", ll_ready, write_reg_addr); end
  endtask

  task automatic test_reset_mid();
    rs_addr = 5'd3;
    wb_valid = 1; wb_addr = 5'd10; wb_data = 32'h1010; iss_valid = 1; iss_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1; ll_addr = (i == 0) ? 5'd3 : 5'(10 + i); ll_data = 32'hB0 + i;
      tick(); iss_valid = 0;
    end
    n_vec++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b exp 1", rs_busy); end
    idle_inputs(); reset = 1; tick(); reset = 0;
    n_vec++; if (write_en !== 1'b0 || ll_ready !== 1'b1 || rs_busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got we=%b rdy=%b busy=%b exp 0/1/0", write_en, ll_ready, rs_busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL mid_nodrain_%0d got %b exp 0", i, write_en); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      wb_valid  = !m_stall && ($urandom_range(0, 9) < 4);
      wb_addr   = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      ll_valid  = ($urandom_range(0, 1) == 1);
      ll_addr   = 5'($urandom_range(0, 31));
      ll_data   = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_addr  = 5'($urandom_range(0, 31));
      rs_addr   = 5'($urandom_range(0, 31));
      rt_addr   = 5'($urandom_range(0, 31));
      tick();
      n_vec++; if (write_en !== m_we || write_reg_addr !== m_addr || write_reg_data !== m_data) begin
        n_err++; $display("FAIL rnd_write c%0d got %b/%0d/%h exp %b/%0d/%h", c,
          write_en, write_reg_addr, write_reg_data, m_we, m_addr, m_data); end
      n_vec++; if (ll_ready !== (exp_q.size() < DEPTH) || pipe_stall !== m_stall) begin
        n_err++; $display("FAIL rnd_ctrl c%0d got rdy=%b stall=%b exp %b/%b", c,
          ll_ready, pipe_stall, exp_q.size() < DEPTH, m_stall); end
      n_vec++; if (rs_busy !== m_busy[rs_addr] || rt_busy !== m_busy[rt_addr]) begin
        n_err++; $display("FAIL rnd_busy c%0d got %b%b exp %b%b", c,
          rs_busy, rt_busy, m_busy[rs_addr], m_busy[rt_addr]); end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; idle_inputs(); rs_addr = 0; rt_addr = 0;
    test_reset();
    test_wb_write();
    test_scoreboard();
    test_set_wins();
    test_starvation();
    test_r0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
